mips_load_store_unit: RTL and testbench
=======================================

Name: mips_load_store_unit

Overview:
Initiator side of the mips_data_mem interface. Accepts load/store requests from the MIPS datapath and drives mem_address, write_data, signal_mem_read and signal_mem_write. Converts byte and halfword accesses into word reads and read-modify-write sequences, sign- or zero-extends loads, and reports misaligned accesses. Sits between the MEM stage and mips_data_mem.

Parameters:
ADDR_WIDTH, 32, width of byte address on both request and memory sides
BIG_ENDIAN, 1, 1 = byte offset 0 maps to bits [31:24] (MIPS); 0 = offset 0 maps to bits [7:0]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  misaligned or reserved size, valid with resp_valid
mem_address  output  ADDR_WIDTH  word-aligned byte address (low 2 bits forced to 0)
write_data  output  32  word written to memory
signal_mem_read  output  1  memory read strobe
signal_mem_write  output  1  memory write strobe; memory writes on the clk edge
read_data  input  32  memory read data, combinational from mem_address while signal_mem_read = 1

Behaviour:
- Reset: state IDLE; resp_valid, resp_error, signal_mem_read, signal_mem_write = 0; resp_rdata, mem_address, write_data = 0. req_ready = 1 in IDLE, including during reset.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready = 1. On accept in cycle N, latch addr, size, unsigned, wdata and write. Next state:
  - Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size 11 -> RESP with error.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD (N+1): signal_mem_read = 1. Extract and extend the lane from read_data, register into resp_rdata -> RESP.
- WR (N+1): signal_mem_write = 1, write_data = req_wdata -> RESP.
- RMW_RD (N+1): signal_mem_read = 1. Register merged word (read_data with target lane replaced by low byte/half of wdata) -> RMW_WR.
- RMW_WR (N+2): signal_mem_write = 1, write_data = merged word -> RESP.
- RESP: resp_valid = 1 for exactly one cycle. resp_error is registered; resp_rdata is held. Then -> IDLE. No response backpressure.
- Latency from accept:
  - Error: resp at N+1.
  - Load / word store: resp at N+2.
  - Sub-word store: resp at N+3.
- Strobe rules: read and write strobes are never high together. mem_address is constant throughout a transaction. Strobes are 0 in IDLE and RESP.
- Lane select, BIG_ENDIAN = 1:
  - Byte offset k -> bits [31-8k -: 8].
  - Half offset 0 -> [31:16]; half offset 2 -> [15:0].
- Error responses perform no memory access; resp_rdata = 0.
- Asynchronous reset mid-transaction: strobes drop immediately and state returns to IDLE. A store abandoned before RMW_WR/WR leaves memory unchanged. No response is generated.
- req_valid is ignored outside IDLE; req_* need not be held after accept.

Decomposition:
- Shared package mips_lsu_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - state enum
  - misalign-check function
- One natural sub-module: mips_lsu_align. It is combinational and provides lane extract/extend for loads and lane merge for stores, parameterised by BIG_ENDIAN. The FSM and registers stay in the top.

Test Plan:
1. Memory word at address 4 = BC1F0F83; lw addr 4 accepted at N. Required: signal_mem_read = 1 only at N+1 with mem_address = 4; resp_valid at N+2; resp_rdata = BC1F0F83; resp_error = 0.
2. Same memory. Required responses:
   - lb addr 4 signed -> FFFFFFBC
   - lbu addr 4 -> 000000BC
   - lb addr 5 -> 0000001F
   - lh addr 6 signed -> 00000F83
   - lhu addr 4 -> 0000BC1F
3. sb addr 6 wdata 000000AA. Required: read at N+1; write at N+2 with write_data = BC1FAA83; resp at N+3; a subsequent lw addr 4 returns BC1FAA83.
4. sw addr 4 wdata F33333B3. Required: signal_mem_write only at N+1; signal_mem_read never asserted; resp at N+2 with rdata 0; subsequent lw returns F33333B3.
5. lh addr 5, then lw addr 6. Required: each gives resp_valid + resp_error at N+1 with no strobes at any point; memory unchanged.
6. Start sh addr 4 wdata 1234 and drop rst_n during RMW_RD. Required: strobes 0 immediately; req_ready = 1; no resp_valid; lw addr 4 after release returns the original word.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: shared size encodings, FSM states and alignment check for the load/store unit
package mips_lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} lsu_state_t;
  // Reserved size counts as misaligned so both error kinds share one path
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_RSVD || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: lane extract/extend for loads and lane merge for stores
module mips_lsu_align
  import mips_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [1:0]  lane;
  logic [4:0]  sh;
  logic [31:0] lane_w;
  logic [31:0] mask;
  // Lane index counts bytes from bit 0; big-endian flips the byte order within the word
  assign lane = BIG_ENDIAN ? (size == SIZE_BYTE ? ~offset : {~offset[1], 1'b0}) : offset;
  assign sh = {size == SIZE_WORD ? 2'b00 : lane, 3'b000};
  assign lane_w = word >> sh;
  assign load_data = size == SIZE_BYTE ? {{24{~is_unsigned & lane_w[7]}}, lane_w[7:0]}
                   : size == SIZE_HALF ? {{16{~is_unsigned & lane_w[15]}}, lane_w[15:0]}
                   : word;
  assign mask = (size == SIZE_BYTE ? 32'h0000_00FF : size == SIZE_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
  assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: turns sub-word loads/stores into word reads and read-modify-write cycles
module mips_load_store_unit
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           write_data,
  output logic                  signal_mem_read,
  output logic                  signal_mem_write,
  input  logic [31:0]           read_data
);
  lsu_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        accept;
  logic        bad;
  assign accept = req_valid && req_ready;
  assign bad = misaligned(req_size, req_addr[1:0]);
  mips_lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .is_unsigned(uns_q),
    .word       (read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merged     (merged)
  );
  // State register; reset aborts any transaction and drops the strobes at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Next state: errors skip memory, loads read once, sub-word stores read then write
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = !accept ? IDLE : bad ? RESP : !req_write ? RD : req_size == SIZE_WORD ? WR : RMW_RD;
      RMW_RD: state_nxt = RMW_WR;
      RD, WR, RMW_WR: state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Request capture, load result and merged store word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      size_q   <= SIZE_BYTE;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      err_q   <= bad;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == RD) begin
      rdata_q <= load_data;
    end else if (state == RMW_RD) begin
      merged_q <= merged;
    end
  end
  assign req_ready        = state == IDLE;
  assign resp_valid       = state == RESP;
  assign resp_error       = state == RESP && err_q;
  assign resp_rdata       = rdata_q;
  assign mem_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign signal_mem_read  = state == RD || state == RMW_RD;
  assign signal_mem_write = state == WR || state == RMW_WR;
  assign write_data       = state == WR ? wdata_q : state == RMW_WR ? merged_q : 32'h0;
endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit: table-driven scoreboard bench with a small word memory
module tb_mips_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic [31:0] read_data;
  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [7:0]  rmask;
    logic [7:0]  wmask;
    logic [31:0] wd;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  mips_load_store_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .write_data(write_data), .signal_mem_read(signal_mem_read),
    .signal_mem_write(signal_mem_write), .read_data(read_data)
  );

  always #5 clk = ~clk;
  assign read_data = signal_mem_read ? mem[mem_address[5:2]] : 32'h0;
  always @(posedge clk) if (signal_mem_write) mem[mem_address[5:2]] <= write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) chk("strobe_exclusive", {31'b0, signal_mem_read & signal_mem_write}, 32'h0);

  task automatic do_req(input vec_t v, input int idx);
    logic [7:0]  rmask = '0;
    logic [7:0]  wmask = '0;
    logic [31:0] wd = '0;
    int          lat = -1;
    exp_t        e;
    string       tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = v.w; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    sb.push_back('{v.rdata, v.err});
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 6; c++) begin
      if (signal_mem_read) rmask[c] = 1'b1;
      if (signal_mem_write) begin
        wmask[c] = 1'b1;
        wd = write_data;
      end
      if (signal_mem_read || signal_mem_write) chk({tag, "_addr"}, mem_address, {v.addr[31:2], 2'b00});
      if (resp_valid) begin
        lat = c;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL %s_unexpected_resp: got response expected none", tag);
        end else begin
          e = sb.pop_front();
          chk({tag, "_rdata"}, resp_rdata, e.rdata);
          chk({tag, "_err"}, {31'b0, resp_error}, {31'b0, e.err});
        end
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rmask"}, {24'b0, rmask}, {24'b0, v.rmask});
    chk({tag, "_wmask"}, {24'b0, wmask}, {24'b0, v.wmask});
    if (v.wmask != 0) chk({tag, "_wdata"}, wd, v.wd);
    @(posedge clk); #1;
    chk({tag, "_resp_once"}, {31'b0, resp_valid}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'hBC1F0F83;
    mem[2] = 32'h11223344;
    // loads on BC1F0F83
    vecs.push_back('{0, 2'b10, 0, 32'd4, 32'h0, 32'hBC1F0F83, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b00, 0, 32'd4, 32'h0, 32'hFFFFFFBC, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b00, 1, 32'd4, 32'h0, 32'h000000BC, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b00, 0, 32'd5, 32'h0, 32'h0000001F, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b01, 0, 32'd6, 32'h0, 32'h00000F83, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b01, 1, 32'd4, 32'h0, 32'h0000BC1F, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b01, 0, 32'd4, 32'h0, 32'hFFFFBC1F, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b00, 0, 32'd7, 32'h0, 32'hFFFFFF83, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b00, 1, 32'd7, 32'h0, 32'h00000083, 0, 2, 8'b010, 8'b000, 32'h0});
    // sub-word store then readback
    vecs.push_back('{1, 2'b00, 0, 32'd6, 32'h000000AA, 32'h0, 0, 3, 8'b010, 8'b100, 32'hBC1FAA83});
    vecs.push_back('{0, 2'b10, 0, 32'd4, 32'h0, 32'hBC1FAA83, 0, 2, 8'b010, 8'b000, 32'h0});
    // word store then readback
    vecs.push_back('{1, 2'b10, 0, 32'd4, 32'hF33333B3, 32'h0, 0, 2, 8'b000, 8'b010, 32'hF33333B3});
    vecs.push_back('{0, 2'b10, 0, 32'd4, 32'h0, 32'hF33333B3, 0, 2, 8'b010, 8'b000, 32'h0});
    // errors: no memory access, memory unchanged
    vecs.push_back('{0, 2'b01, 0, 32'd5, 32'h0, 32'h0, 1, 1, 8'b000, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b10, 0, 32'd6, 32'h0, 32'h0, 1, 1, 8'b000, 8'b000, 32'h0});
    vecs.push_back('{1, 2'b11, 0, 32'd4, 32'h12345678, 32'h0, 1, 1, 8'b000, 8'b000, 32'h0});
    vecs.push_back('{1, 2'b10, 0, 32'd5, 32'h12345678, 32'h0, 1, 1, 8'b000, 8'b000, 32'h0});
    vecs.push_back('{0, 2'b10, 0, 32'd4, 32'h0, 32'hF33333B3, 0, 2, 8'b010, 8'b000, 32'h0});
    // more sub-word merges
    vecs.push_back('{1, 2'b01, 0, 32'd6, 32'hABCD1234, 32'h0, 0, 3, 8'b010, 8'b100, 32'hF3331234});
    vecs.push_back('{1, 2'b00, 0, 32'd4, 32'hFFFFFF55, 32'h0, 0, 3, 8'b010, 8'b100, 32'h55331234});
    vecs.push_back('{0, 2'b10, 0, 32'd4, 32'h0, 32'h55331234, 0, 2, 8'b010, 8'b000, 32'h0});
    vecs.push_back('{1, 2'b00, 0, 32'd11, 32'h0000007E, 32'h0, 0, 3, 8'b010, 8'b100, 32'h1122337E});
    vecs.push_back('{0, 2'b10, 0, 32'd8, 32'h0, 32'h1122337E, 0, 2, 8'b010, 8'b000, 32'h0});

    // reset state, held for a few cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'h0);
    chk("rst_rd", {31'b0, signal_mem_read}, 32'h0);
    chk("rst_wr", {31'b0, signal_mem_write}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

    // reset during the read half of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'd4; req_wdata = 32'h00001234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_rmw_rd", {31'b0, signal_mem_read}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_drop", {31'b0, signal_mem_read}, 32'h0);
    chk("abort_wr_drop", {31'b0, signal_mem_write}, 32'h0);
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_no_resp", {31'b0, resp_valid}, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_hold_no_resp", {31'b0, resp_valid | signal_mem_write}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_after_no_resp", {31'b0, resp_valid}, 32'h0);
    end
    do_req('{0, 2'b10, 0, 32'd4, 32'h0, 32'h55331234, 0, 2, 8'b010, 8'b000, 32'h0}, 99);

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
